// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared mode encodings, event indices and width helper for the LED step sequencer.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_PAUSE = 2'b10
    } mode_e;

    localparam int EV_RUN  = 0;
    localparam int EV_DIR  = 1;
    localparam int EV_FAST = 2;
    localparam int EV_SLOW = 3;

    function automatic int pw_f(input int max_v);
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/led_step_ctrl_key_event.sv
// key_event: rising-edge press detector with a one-cycle event pulse.
// With LED_REPEAT_EN defined, a held key (REP=1) re-fires every LONG_CYCLES cycles after the press.
module key_event
`ifdef LED_REPEAT_EN
#(
    parameter int LONG_CYCLES = 100,
    parameter bit REP         = 1'b1
)
`endif
(
    input  logic clk_100Hz,
    input  logic rst,
    input  logic pb_i,
    output logic ev_o
);
    logic pb_q, ev_q, ev_d;
`ifdef LED_REPEAT_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    logic [HW-1:0] hold_q, hold_d;
    logic          rep;
    // Counting only starts from a real press, so a key held through reset never repeats.
    always_comb begin
        rep    = REP && pb_i && (hold_q >= HW'(LONG_CYCLES));
        hold_d = !pb_i ? '0 : rep ? HW'(1) : (hold_q != '0 || !pb_q) ? hold_q + 1'b1 : '0;
        ev_d   = (pb_i & ~pb_q) | rep;
    end
    always_ff @(posedge clk_100Hz or posedge rst)
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
`else
    always_comb ev_d = pb_i & ~pb_q;
`endif
    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            pb_q <= 1'b1;
            ev_q <= 1'b0;
        end else begin
            pb_q <= pb_i;
            ev_q <= ev_d;
        end
    end
    assign ev_o = ev_q;
endmodule

// File: rtl/led_step_ctrl.sv
// led_step_ctrl: queues key presses, services one per cycle (run>dir>faster>slower) and walks a lit LED.
// Optional LED_REPEAT_EN adds hold-to-repeat on the faster/slower keys.
module led_step_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int STEP_DEF = 25,
    parameter int STEP_MIN = 5,
    parameter int STEP_MAX = 100,
    parameter int STEP_INC = 5,
`ifdef LED_REPEAT_EN
    parameter int LONG_CYCLES = 100,
`endif
    localparam int PW = pw_f(STEP_MAX)
)(
    input  logic             clk_100Hz,
    input  logic             rst,
    input  logic             pb_run,
    input  logic             pb_dir,
    input  logic             pb_faster,
    input  logic             pb_slower,
    output logic [N_LED-1:0] led,
    output logic [1:0]       mode,
    output logic [PW-1:0]    period,
    output logic             dir
);
    localparam logic [PW-1:0] P_DEF = PW'(STEP_DEF);
    localparam logic [PW-1:0] P_MIN = PW'(STEP_MIN);
    localparam logic [PW-1:0] P_MAX = PW'(STEP_MAX);
    localparam logic [PW-1:0] P_INC = PW'(STEP_INC);

    logic [3:0]       pb, ev, pend_q, pend_d, svc;
    mode_e            mode_q, mode_d;
    logic [N_LED-1:0] led_q, led_d;
    logic [PW-1:0]    per_q, per_d, cnt_q, cnt_d;
    logic             dir_q, dir_d;

    assign pb = {pb_slower, pb_faster, pb_dir, pb_run};

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_event
`ifdef LED_REPEAT_EN
            #(.LONG_CYCLES(LONG_CYCLES), .REP(k >= EV_FAST))
`endif
            u_key (.clk_100Hz(clk_100Hz), .rst(rst), .pb_i(pb[k]), .ev_o(ev[k]));
    end

    // Lowest set bit wins, which is exactly run > dir > faster > slower.
    assign svc    = pend_q & (~pend_q + 4'd1);
    assign pend_d = (pend_q & ~svc) | ev;

    // Stepping reads the registered dir/period, so an event serviced this cycle affects the next step.
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        per_d  = per_q;
        if (mode_q == MODE_RUN) begin
            cnt_d = (cnt_q >= per_q - PW'(1)) ? '0 : cnt_q + 1'b1;
            led_d = (cnt_q < per_q - PW'(1)) ? led_q :
                    dir_q ? {led_q[0], led_q[N_LED-1:1]} : {led_q[N_LED-2:0], led_q[N_LED-1]};
        end
        if (svc[EV_RUN]) begin
            mode_d = (mode_q == MODE_RUN) ? MODE_PAUSE : MODE_RUN;
            if (mode_q == MODE_IDLE) begin
                led_d = dir_q ? {1'b1, {(N_LED-1){1'b0}}} : N_LED'(1);
                cnt_d = '0;
            end
        end
        if (svc[EV_DIR])  dir_d = ~dir_q;
        if (svc[EV_FAST]) per_d = (per_q <= P_MIN + P_INC) ? P_MIN : per_q - P_INC;
        if (svc[EV_SLOW]) per_d = (per_q >= P_MAX - P_INC) ? P_MAX : per_q + P_INC;
    end

    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            mode_q <= MODE_IDLE;
            led_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            per_q  <= P_DEF;
        end else begin
            pend_q <= pend_d;
            mode_q <= mode_d;
            led_q  <= led_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            per_q  <= per_d;
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign period = per_q;
    assign dir    = dir_q;
endmodule

// File: tb/tb_led_step_ctrl.sv
// tb_led_step_ctrl: directed scoreboard bench for led_step_ctrl; expectations follow LED_REPEAT_EN when defined.
module tb_led_step_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pb  = 4'b0;
    logic [7:0] led;
    logic [1:0] mode;
    logic [6:0] period;
    logic       dir;
    int         total = 0;
    int         bad   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    led_step_ctrl dut (
        .clk_100Hz(clk), .rst(rst),
        .pb_run(pb[0]), .pb_dir(pb[1]), .pb_faster(pb[2]), .pb_slower(pb[3]),
        .led(led), .mode(mode), .period(period), .dir(dir)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // sel: 0 mode, 1 led, 2 period, 3 dir
    task automatic push(input string tag, input int sel, input int val);
        sb.push_back('{tag, sel, 32'(val)});
    endtask

    task automatic flush();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.sel == 0) ? {30'b0, mode} : (e.sel == 1) ? {24'b0, led} :
                  (e.sel == 2) ? {25'b0, period} : {31'b0, dir};
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pb  = 4'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic press(input int k);
        pb[k] = 1'b1;
        tick(1);
        pb[k] = 1'b0;
        tick(2);
    endtask

    initial begin
        int p;
        // 1: reset state, start and first step
        do_reset();
        push("rst_mode", 0, 0); push("rst_led", 1, 0); push("rst_per", 2, 25); push("rst_dir", 3, 0);
        flush();
        pb[0] = 1'b1;
        tick(3);
        pb[0] = 1'b0;
        push("start_mode", 0, 1); push("start_led", 1, 8'h01); flush();
        tick(24);
        push("pre_step_led", 1, 8'h01); flush();
        tick(1);
        push("step_led", 1, 8'h02); flush();
        // 2: period saturation both ways
        p = 25;
        for (int i = 0; i < 5; i++) begin
            press(2);
            p = (p - 5 < 5) ? 5 : p - 5;
            push("faster_per", 2, p); flush();
        end
        for (int i = 0; i < 20; i++) begin
            press(3);
            p = (p + 5 > 100) ? 100 : p + 5;
            push("slower_per", 2, p); flush();
        end
        // 3: simultaneous run+dir+faster serviced in priority order
        do_reset();
        pb = 4'b0111;
        tick(3);
        push("pri_run_mode", 0, 1); push("pri_run_dir", 3, 0); push("pri_run_per", 2, 25); flush();
        tick(1);
        push("pri_dir_dir", 3, 1); push("pri_dir_per", 2, 25); flush();
        tick(1);
        pb = 4'b0;
        push("pri_fast_per", 2, 20); push("pri_fast_led", 1, 8'h01); flush();
        tick(17);
        push("rdir_pre_led", 1, 8'h01); flush();
        tick(1);
        push("rdir_step_led", 1, 8'h80); flush();
        // 4: period cut below running count, then pause/resume
        do_reset();
        press(0);
        tick(10);
        pb[2] = 1'b1; tick(1); pb[2] = 1'b0; tick(1);
        pb[2] = 1'b1; tick(1); pb[2] = 1'b0; tick(1);
        push("cut_per20", 2, 20); push("cut_led_a", 1, 8'h01); flush();
        tick(1);
        push("cut_per15", 2, 15); push("cut_led_b", 1, 8'h01); flush();
        tick(1);
        push("cut_step_led", 1, 8'h02); flush();
        tick(14);
        push("cut_hold_led", 1, 8'h02); flush();
        tick(1);
        push("cut_next_led", 1, 8'h04); flush();
        press(0);
        push("pause_mode", 0, 2); push("pause_led", 1, 8'h04); flush();
        tick(200);
        push("pause_mode_200", 0, 2); push("pause_led_200", 1, 8'h04); flush();
        press(0);
        push("resume_mode", 0, 1); push("resume_led", 1, 8'h04); flush();
        tick(11);
        push("resume_pre_led", 1, 8'h04); flush();
        tick(1);
        push("resume_step_led", 1, 8'h08); flush();
        // 5: key held through reset, then async reset mid-run
        rst   = 1'b1;
        pb[0] = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        push("held_mode", 0, 0); push("held_led", 1, 0); flush();
        pb[0] = 1'b0;
        tick(3);
        push("held_rel_mode", 0, 0); flush();
        press(0);
        press(1);
        press(2);
        push("mid_mode", 0, 1); push("mid_dir", 3, 1); push("mid_per", 2, 20); flush();
        tick(5);
        #3 rst = 1'b1;
        #1;
        push("arst_mode", 0, 0); push("arst_led", 1, 0); push("arst_per", 2, 25); push("arst_dir", 3, 0);
        flush();
        tick(1);
        rst = 1'b0;
        tick(1);
        // 6: long hold of slower
        do_reset();
        pb[3] = 1'b1;
        tick(350);
        pb[3] = 1'b0;
        tick(5);
`ifdef LED_REPEAT_EN
        push("hold_per", 2, 45);
`else
        push("hold_per", 2, 30);
`endif
        push("hold_mode", 0, 0); flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
